// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared state encoding and funct3 size/sign codes for the
//               load/store access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RD   = c_ST_RD,
        WR   = c_ST_WR,
        DONE = c_ST_DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants.
    function automatic logic f3Valid(input logic isStore, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!isStore && ((f3 == F3_BU) || (f3 == F3_HU)))
            ok = 1'b1;
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lane_align
// Description : Little-endian byte/halfword lane merge for stores and lane
//               extract with sign/zero extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] mergedWord,
    output logic [31:0] loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = word[{lane, 3'b000} +: 8];
        w_half     = lane[1] ? word[31:16] : word[15:0];
        mergedWord = word;
        loadData   = word;
        case (funct3)
            F3_B:    mergedWord[{lane, 3'b000} +: 8]   = wdata[7:0];
            F3_H:    mergedWord[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: mergedWord = wdata;
        endcase
        case (funct3)
            F3_B:    loadData = {{24{w_byte[7]}}, w_byte};
            F3_BU:   loadData = {24'h000000, w_byte};
            F3_H:    loadData = {{16{w_half[15]}}, w_half};
            F3_HU:   loadData = {16'h0000, w_half};
            default: loadData = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Single-port load/store sequencer; sub-word stores are done as
//               read-modify-write because the memory has no byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] memAdr,
    output logic [31:0] writeData,
    output logic        memWrite,
    input  logic [31:0] readData
);

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_word;
    logic        r_we, r_err;
    logic [2:0]  r_f3;

    logic        w_isHalf, w_isWord, w_misalign, w_reqBad;
    logic [1:0]  w_lane;
    logic [31:0] w_srcWord, w_merged, w_loadData;

    always_comb begin
        w_isHalf   = (funct3 == F3_H) || (funct3 == F3_HU);
        w_isWord   = (funct3 == F3_W);
        w_misalign = ALIGN_CHECK && ((w_isHalf && addr[0]) || (w_isWord && (addr[1:0] != 2'b00)));
        w_reqBad   = !f3Valid(we, funct3) || w_misalign;
    end

    // Lane offset honours the access size so unaligned low bits are ignored when unchecked.
    always_comb begin
        case (r_f3)
            F3_B, F3_BU: w_lane = r_addr[1:0];
            F3_H, F3_HU: w_lane = {r_addr[1], 1'b0};
            default:     w_lane = 2'b00;
        endcase
    end

    assign w_srcWord = (r_state == RD) ? readData : r_word;

    lane_align u_lane_align (
        .word       (w_srcWord),
        .wdata      (r_wdata),
        .funct3     (r_f3),
        .lane       (w_lane),
        .mergedWord (w_merged),
        .loadData   (w_loadData)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_reqBad)
                        w_next = DONE;
                    else if (we && w_isWord)
                        w_next = WR;
                    else
                        w_next = RD;
                end
            end
            RD:      w_next = r_we ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_err   <= 1'b0;
            rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= we;
                r_f3    <= funct3;
                r_err   <= w_reqBad;
            end
            if (r_state == RD) begin
                r_word <= readData;
                if (!r_we)
                    rdata <= w_loadData;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err       = done && r_err;
    assign memAdr    = busy ? {r_addr[31:2], 2'b00} : 32'h0;
    assign writeData = (r_state == WR) ? w_merged : 32'h0;
    assign memWrite  = (r_state == WR) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               small word-addressed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, memAdr, writeData, readData;
    logic        busy, done, err, memWrite;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign readData = mem[memAdr[9:2]];
    always @(posedge clk) if (memWrite) mem[memAdr[9:2]] <= writeData;

    mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .err(err), .memAdr(memAdr), .writeData(writeData), .memWrite(memWrite),
        .readData(readData)
    );

    // Waits for IDLE, issues one request, scrambles inputs after the sampling edge,
    // and reports the cycle done appeared in plus write activity.
    task automatic run_access(input logic iwe, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output int dcyc, output logic derr,
                              output int nwr, output logic [31:0] lastWd);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b1; we = iwe; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = ~iwe; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        dcyc = 0; derr = 1'b0; nwr = 0; lastWd = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (memWrite) begin
                nwr++;
                lastWd = writeData;
            end
            if (done) begin
                dcyc = c;
                derr = err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (memAdr !== 32'h0) begin bad++; $display("FAIL reset_memAdr got=%h exp=0", memAdr); end
        total++; if (memWrite !== 1'b0) begin bad++; $display("FAIL reset_memWrite got=%b exp=0", memWrite); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loads();
        int dc, nw; logic de; logic [31:0] lw;
        mem[64] = 32'h80FF7F01;
        run_access(1'b0, F3_B, 32'h103, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_103 got=%h exp=ffffff80", rdata); end
        total++; if (dc !== 2) begin bad++; $display("FAIL lb_latency got=%0d exp=2", dc); end
        total++; if (de !== 1'b0 || nw !== 0) begin bad++; $display("FAIL lb_err_wr got=%b/%0d exp=0/0", de, nw); end
        run_access(1'b0, F3_BU, 32'h103, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_103 got=%h exp=00000080", rdata); end
        run_access(1'b0, F3_H, 32'h102, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'hFFFF80FF) begin bad++; $display("FAIL lh_102 got=%h exp=ffff80ff", rdata); end
        run_access(1'b0, F3_HU, 32'h100, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'h00007F01) begin bad++; $display("FAIL lhu_100 got=%h exp=00007f01", rdata); end
        run_access(1'b0, F3_W, 32'h100, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'h80FF7F01) begin bad++; $display("FAIL lw_100 got=%h exp=80ff7f01", rdata); end
        total++; if (dc !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", dc); end
        run_access(1'b0, F3_B, 32'h101, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'h0000007F) begin bad++; $display("FAIL lb_101 got=%h exp=0000007f", rdata); end
    endtask

    task automatic test_store_byte();
        int dc, nw; logic de; logic [31:0] lw;
        mem[64] = 32'h11223344;
        run_access(1'b1, F3_B, 32'h101, 32'h123456AB, dc, de, nw, lw);
        total++; if (nw !== 1) begin bad++; $display("FAIL sb_writes got=%0d exp=1", nw); end
        total++; if (lw !== 32'h1122AB44) begin bad++; $display("FAIL sb_writeData got=%h exp=1122ab44", lw); end
        total++; if (dc !== 3) begin bad++; $display("FAIL sb_latency got=%0d exp=3", dc); end
        total++; if (mem[64] !== 32'h1122AB44) begin bad++; $display("FAIL sb_mem got=%h exp=1122ab44", mem[64]); end
    endtask

    task automatic test_store_half();
        int dc, nw; logic de; logic [31:0] lw;
        mem[64] = 32'h11223344;
        run_access(1'b1, F3_H, 32'h102, 32'hFFFF5A5A, dc, de, nw, lw);
        total++; if (mem[64] !== 32'h5A5A3344) begin bad++; $display("FAIL sh_mem got=%h exp=5a5a3344", mem[64]); end
        total++; if (dc !== 3 || nw !== 1) begin bad++; $display("FAIL sh_lat_wr got=%0d/%0d exp=3/1", dc, nw); end
        run_access(1'b0, F3_H, 32'h102, 32'h0, dc, de, nw, lw);
        total++; if (rdata !== 32'h00005A5A) begin bad++; $display("FAIL lh_after_sh got=%h exp=00005a5a", rdata); end
        run_access(1'b0, F3_HU, 32'h103, 32'h0, dc, de, nw, lw);
        total++; if (de !== 1'b1 || dc !== 1) begin bad++; $display("FAIL lhu_misalign got=%b/%0d exp=1/1", de, dc); end
        total++; if (rdata !== 32'h00005A5A) begin bad++; $display("FAIL lhu_rdata_hold got=%h exp=00005a5a", rdata); end
    endtask

    task automatic test_store_word();
        int dc, nw; logic de; logic [31:0] lw;
        mem[65] = 32'h0;
        run_access(1'b1, F3_W, 32'h104, 32'hDEADBEEF, dc, de, nw, lw);
        total++; if (dc !== 2 || nw !== 1) begin bad++; $display("FAIL sw_lat_wr got=%0d/%0d exp=2/1", dc, nw); end
        total++; if (lw !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_writeData got=%h exp=deadbeef", lw); end
        total++; if (mem[65] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[65]); end
    endtask

    task automatic test_errors();
        int dc, nw; logic de; logic [31:0] lw;
        run_access(1'b0, F3_W, 32'h102, 32'h0, dc, de, nw, lw);
        total++; if (dc !== 1 || de !== 1'b1) begin bad++; $display("FAIL lw_misalign got=%0d/%b exp=1/1", dc, de); end
        total++; if (nw !== 0) begin bad++; $display("FAIL lw_misalign_wr got=%0d exp=0", nw); end
        total++; if (rdata !== 32'h00005A5A) begin bad++; $display("FAIL lw_misalign_rdata got=%h exp=00005a5a", rdata); end
        run_access(1'b1, F3_W, 32'h101, 32'hCAFEF00D, dc, de, nw, lw);
        total++; if (de !== 1'b1 || nw !== 0 || mem[64] !== 32'h5A5A3344) begin
            bad++; $display("FAIL sw_misalign got=%b/%0d/%h exp=1/0/5a5a3344", de, nw, mem[64]);
        end
        run_access(1'b0, 3'b011, 32'h100, 32'h0, dc, de, nw, lw);
        total++; if (de !== 1'b1 || dc !== 1) begin bad++; $display("FAIL ld_bad_f3 got=%b/%0d exp=1/1", de, dc); end
        run_access(1'b1, F3_BU, 32'h100, 32'h0, dc, de, nw, lw);
        total++; if (de !== 1'b1 || nw !== 0) begin bad++; $display("FAIL st_bad_f3 got=%b/%0d exp=1/0", de, nw); end
    endtask

    task automatic test_reset_in_wr();
        int dseen;
        mem[64] = 32'h11223344;
        @(negedge clk);
        while (busy) @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h101; wdata = 32'h000000AB;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        total++; if (memWrite !== 1'b1 || writeData !== 32'h1122AB44) begin
            bad++; $display("FAIL rmw_wr_cycle got=%b/%h exp=1/1122ab44", memWrite, writeData);
        end
        rst = 1'b1;
        #1;
        total++; if (memWrite !== 1'b0) begin bad++; $display("FAIL rst_wr_memWrite got=%b exp=0", memWrite); end
        @(posedge clk); #1;
        total++; if (mem[64] !== 32'h11223344) begin bad++; $display("FAIL rst_wr_mem got=%h exp=11223344", mem[64]); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_wr_state got=%b/%b exp=0/0", busy, done); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_wr_rdata got=%h exp=0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dseen++;
        end
        total++; if (dseen !== 0) begin bad++; $display("FAIL rst_wr_no_done got=%0d exp=0", dseen); end
    endtask

    task automatic test_back_to_back();
        mem[64] = 32'h11223344;
        mem[65] = 32'h000000C5;
        @(negedge clk);
        while (busy) @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = F3_BU; addr = 32'h100; wdata = 32'h0;
        @(posedge clk); #1;
        addr = 32'h104;
        total++; if (memAdr !== 32'h100 || busy !== 1'b1) begin bad++; $display("FAIL b2b_c1 got=%h/%b exp=100/1", memAdr, busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1 || rdata !== 32'h44) begin bad++; $display("FAIL b2b_c2 got=%b/%h exp=1/44", done, rdata); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_c3_idle got=%b exp=0", busy); end
        @(posedge clk); #1;
        req = 1'b0;
        total++; if (busy !== 1'b1 || memAdr !== 32'h104) begin bad++; $display("FAIL b2b_c4 got=%b/%h exp=1/104", busy, memAdr); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1 || rdata !== 32'hC5) begin bad++; $display("FAIL b2b_c5 got=%b/%h exp=1/c5", done, rdata); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_store_byte();
        test_store_half();
        test_store_word();
        test_errors();
        test_reset_in_wr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and rst.
REQ-002 Parameter ALIGN_CHECK, default 1: when 1, misaligned halfword/word accesses are rejected; when 0, the low address bits are ignored per access size.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  1  CPU access request; sampled only in IDLE.
REQ-006 we  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (stores accept 000/001/010 only).
REQ-008 addr  in  32  byte address; wdata  in  32  store data, low bits used for b/h.
REQ-009 rdata  out  32  extended load result; busy  out  1  state != IDLE; done  out  1  one-cycle completion pulse; err  out  1  valid with done.
REQ-010 memAdr  out  32  word-aligned address {a[31:2],2'b00}; writeData  out  32  full merged word; memWrite  out  1  write strobe.
REQ-011 readData  in  32  combinational word read of memAdr; the memory writes all four bytes at posedge when memWrite=1 and has no byte enables.

Function
REQ-012 The FSM SHALL have the states IDLE, RD, WR and DONE.
REQ-013 In IDLE with req=1, addr, wdata, we and funct3 SHALL be latched; later input changes SHALL NOT affect the access.
REQ-014 IDLE transitions: a load or a sb/sh SHALL go to RD; a sw SHALL go to WR; a misaligned access (ALIGN_CHECK=1) or an unsupported funct3 SHALL go to DONE with err=1 and no memory access.
REQ-015 RD SHALL drive memAdr and capture readData at the end of the cycle; a load SHALL then go to DONE, and a sb/sh SHALL go to WR.
REQ-016 WR SHALL assert memWrite=1 for exactly one cycle, with writeData equal to the captured word with the addressed byte or halfword lanes replaced by wdata[7:0] or wdata[15:0]; for sw, writeData SHALL equal wdata.
REQ-017 DONE SHALL assert done=1 for one cycle, then go to IDLE; req SHALL NOT be accepted in DONE.
REQ-018 Load extraction SHALL select the lane by addr[1:0] (little-endian): b/h sign-extend; bu/hu zero-extend.
REQ-019 rdata SHALL update only when a load completes without error, and SHALL hold until the next successful load.
REQ-020 Latency counted from the req-sampling edge: load done in cycle 2; sw done in cycle 2; sb/sh done in cycle 3; error done in cycle 1.
REQ-021 Halfword access is misaligned when a[0]=1; word access is misaligned when a[1:0]!=0.
REQ-022 memAdr SHALL be the latched aligned address in RD, WR and DONE, and 0 in IDLE; writeData SHALL be 0 outside WR.
REQ-023 memWrite SHALL equal (state==WR) AND NOT rst.

Reset
REQ-024 When rst=1 at a posedge, state SHALL become IDLE and rdata, done, err, busy and the latches SHALL clear to 0, regardless of the current state.
REQ-025 If rst=1 during a WR cycle, no memory write SHALL occur, and the in-flight read-modify-write SHALL be abandoned with no done pulse.

Structure
REQ-026 Package mem_access_pkg SHALL hold the state enum and the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-027 One combinational sub-module, lane_align, SHALL implement store lane merge and load lane extract/extend; the FSM and registers SHALL stay in mem_access_unit.

Verification
REQ-028 Word 0x100 = 0x80FF7F01; lb at 0x103 -> rdata 0xFFFFFF80, done in cycle 2; lbu at 0x103 -> 0x00000080.
REQ-029 Word 0x100 = 0x11223344; sb wdata 0xAB at 0x101 -> single memWrite cycle with writeData 0x1122AB44, done in cycle 3.
REQ-030 sh 0x5A5A at 0x102 on 0x11223344 -> word 0x5A5A3344; then lh at 0x102 -> rdata 0x00005A5A; lhu at 0x103 (ALIGN_CHECK=1) -> err=1.
REQ-031 lw at 0x102 -> done and err in cycle 1, memWrite never asserted, rdata unchanged.
REQ-032 sb at 0x101 with rst=1 during the WR cycle -> memWrite stays 0, word 0x100 unchanged, busy=0 next cycle, no done pulse.
REQ-033 req held high with addr changed while busy -> the first access uses its original address, and the second access is accepted only on the cycle after done.
